// File: rtl/rt_packet_injector.sv
// rt_packet_injector: FIFO-buffered sender for a router local port over a 2-phase req/ack bundled-data link
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_dst_x/in_dst_y/in_payload (source side);
//        tx_req/tx_data/tx_ack (2-phase link, tx_ack asynchronous); busy, sent_count, err_dst, err_timeout (status).
// Optional: define RT_INJ_TIMEOUT_EN to add the ack-timeout counter behind err_timeout.
module rt_packet_injector #(
    parameter int n       = 32,
    parameter int n_x     = 2,
    parameter int n_y     = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_dst_x,
    input  logic [1:0]   in_dst_y,
    input  logic [n-5:0] in_payload,
    output logic         tx_req,
    output logic [n-1:0] tx_data,
    input  logic         tx_ack,
    output logic         busy,
    output logic [15:0]  sent_count,
    output logic         err_dst,
    output logic         err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [2:0] NX = 3'(n_x);
    localparam logic [2:0] NY = 3'(n_y);

    if (n < 8 || n_x < 1 || n_x > 4 || n_y < 1 || n_y > 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("rt_packet_injector: illegal parameter set");
    end

    logic [n-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_ack_m;
    logic          r_ack_s;
    logic [1:0]    r_state;
    logic          r_req;
    logic [n-1:0]  r_data;
    logic [15:0]   r_sent;
    logic          r_err_dst;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_link_idle;
    logic          w_bad_dst;

    // full/empty come from registered pointers only, so a same-cycle pop never reaches in_ready
    assign w_empty     = r_wr_ptr == r_rd_ptr;
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push      = in_valid && !w_full;
    // phases equal means nothing outstanding; a stray ack leaves them unequal and holds the link off
    assign w_link_idle = r_ack_s == r_req;
    assign w_bad_dst   = ({1'b0, in_dst_x} >= NX) || ({1'b0, in_dst_y} >= NY);

    assign in_ready   = !w_full;
    assign tx_req     = r_req;
    assign tx_data    = r_data;
    assign busy       = !w_empty || r_state != S_IDLE;
    assign sent_count = r_sent;
    assign err_dst    = r_err_dst;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {in_dst_x, in_dst_y, in_payload};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ack_m   <= 1'b0;
            r_ack_s   <= 1'b0;
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_data    <= '0;
            r_sent    <= '0;
            r_err_dst <= 1'b0;
        end else begin
            r_ack_m <= tx_ack;
            r_ack_s <= r_ack_m;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_bad_dst) r_err_dst <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (w_link_idle && !w_empty) begin
                    r_data   <= r_mem[r_rd_ptr[AW-1:0]];
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_state  <= S_SETUP;
                end
                // data has been stable for a full cycle before the request edge
                S_SETUP: begin
                    r_req   <= !r_req;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (w_link_idle) begin
                    r_sent  <= r_sent + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RT_INJ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_to_cnt;
    logic        r_err_to;

    // counter saturates; WAIT is never left on timeout because re-toggling would break the phase pairing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err_to <= 1'b0;
        end else if (r_state == S_SETUP) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
            else r_err_to <= 1'b1;
        end
    end

    assign err_timeout = r_err_to;
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rt_packet_injector.sv
// tb_rt_packet_injector: randomized + directed bench for rt_packet_injector with a queue-based reference model
module tb_rt_packet_injector;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_dst_x;
    logic [1:0]  in_dst_y;
    logic [27:0] in_payload;
    logic        tx_req;
    logic [31:0] tx_data;
    logic        tx_ack;
    logic        busy;
    logic [15:0] sent_count;
    logic        err_dst;
    logic        err_timeout;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_acked = 0;
    int          kick_req = 0;
    int          kick_done = 0;
    int          ack_dly = 3;
    logic        exp_err = 0;
    logic [31:0] exp_q[$];

    rt_packet_injector #(.n(32), .n_x(2), .n_y(2), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_dst_x(in_dst_x), .in_dst_y(in_dst_y), .in_payload(in_payload),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .busy(busy),
        .sent_count(sent_count), .err_dst(err_dst), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pkt(input int x, input int y, input logic [27:0] p);
        return 32'(x) * 32'h4000_0000 + 32'(y) * 32'h1000_0000 + {4'b0, p};
    endfunction

    // router side of the link: each req change consumes the oldest expected word, acks after a delay
    task automatic router();
        logic        last_req = 1'b0;
        logic [31:0] d;
        int          dly;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tx_ack = 1'b0;
                last_req = 1'b0;
                n_acked = 0;
                kick_done = kick_req;
            end else if (kick_done != kick_req) begin
                kick_done++;
                tx_ack = ~tx_ack;
            end else if (tx_req != last_req) begin
                last_req = tx_req;
                if (exp_q.size() == 0) chk("req_has_pkt", exp_q.size(), 1);
                else begin
                    d = exp_q.pop_front();
                    chk("tx_data", tx_data, d);
                    dly = ack_dly < 0 ? int'($urandom_range(0, 10)) : ack_dly;
                    for (int i = 0; i < dly && rst_n; i++) begin
                        @(negedge clk);
                        if (rst_n) begin
                            chk("data_hold", tx_data, d);
                            chk("req_hold", tx_req, last_req);
                        end
                    end
                    if (rst_n) begin
                        tx_ack = ~tx_ack;
                        n_acked++;
                    end
                end
            end
        end
    endtask

    task automatic push(input int x, input int y, input logic [27:0] p);
        int w = 0;
        in_valid = 1'b1;
        in_dst_x = 2'(x);
        in_dst_y = 2'(y);
        in_payload = p;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", in_ready, 1);
        if (in_ready) begin
            exp_q.push_back(pkt(x, y, p));
            if (x >= 2 || y >= 2) exp_err = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while ((busy || exp_q.size() != 0) && w < 3000);
        chk("drain_busy", busy, 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        logic r0;
        int   w;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_dst_x = '0;
        in_dst_y = '0;
        in_payload = '0;
        tx_ack = 1'b0;
        fork
            router();
            begin
                #600000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        repeat (3) @(negedge clk);
        chk("rst_req", tx_req, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_dst", err_dst, 0);
        chk("rst_err_to", err_timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_ready, 1);

        ack_dly = 3;
        push(1, 0, 28'h0ABCDEF);
        chk("lat_req_t0", tx_req, 0);
        @(negedge clk);
        chk("lat_req_t1", tx_req, 0);
        chk("lat_data_setup", tx_data, pkt(1, 0, 28'h0ABCDEF));
        @(negedge clk);
        chk("lat_req_t2", tx_req, 1);
        drain();
        chk("single_sent", sent_count, 1);

        ack_dly = 20;
        push(0, 1, 28'h1234567);
        drain();
        chk("slow_sent", sent_count, 2);
        chk("slow_req", tx_req, 0);

        ack_dly = 2;
        kick_req++;
        repeat (4) @(negedge clk);
        push(0, 0, 28'd1);
        push(0, 1, 28'd2);
        push(1, 0, 28'd3);
        push(1, 1, 28'd4);
        chk("hold_ready", in_ready, 0);
        chk("hold_busy", busy, 1);
        chk("hold_req", tx_req, 0);
        chk("hold_sent", sent_count, 2);
        kick_req++;
        drain();
        chk("b2b_req", tx_req, 0);
        chk("b2b_sent", sent_count, 6);
        chk("b2b_err_dst", err_dst, 0);

        push(2, 0, 28'h00000AA);
        chk("bad_err_dst", err_dst, 1);
        drain();
        chk("bad_sent", sent_count, 7);
        chk("bad_err_sticky", err_dst, 1);

        ack_dly = -1;
        for (int k = 0; k < 40; k++) begin
            push(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 28'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        chk("rnd_sent", sent_count, 32'(16'(n_acked)));
        chk("rnd_err_dst", err_dst, exp_err);
`ifndef RT_INJ_TIMEOUT_EN
        chk("rnd_err_to", err_timeout, 0);
`endif

        if (tx_req) begin
            ack_dly = 0;
            push(1, 1, 28'h0000055);
            drain();
        end
        ack_dly = 30;
        push(1, 1, 28'h5A5A5A5);
        w = 0;
        while (tx_req != 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mid_wait_req", tx_req, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_req", tx_req, 0);
        chk("arst_sent", sent_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_err_dst", err_dst, 0);
        chk("arst_err_to", err_timeout, 0);
        exp_q.delete();
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", in_ready, 1);
        ack_dly = -1;
        push(0, 1, 28'h0FEDCBA);
        drain();
        chk("post_rst_sent", sent_count, 1);

`ifdef RT_INJ_TIMEOUT_EN
        ack_dly = 40;
        r0 = tx_req;
        push(1, 0, 28'h0000777);
        w = 0;
        while (tx_req == r0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("to_wait_entry", tx_req, !r0);
        chk("to_k0", err_timeout, 0);
        repeat (15) @(negedge clk);
        chk("to_k15", err_timeout, 0);
        @(negedge clk);
        chk("to_k16", err_timeout, 1);
        chk("to_no_retx", tx_req, !r0);
        drain();
        chk("to_sticky", err_timeout, 1);
`else
        r0 = tx_req;
        chk("to_off", err_timeout, 0);
        chk("end_req_phase", tx_req, r0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
